spike_time_capture: RTL and testbench
=====================================

# spike_time_capture

Temporal decoder for the clocked STDP datapath: converts N level-coded spike lines back into per-line spike times within one gamma window, the inverse of spike generation. It owns a window time counter, exported as `time_val` so upstream spike generators can share it. It latches the first cycle each line is seen high and presents the decoded times with a valid/ready handshake. It sits between a neuron/generator column and the weight-update (STDP) logic.

## Interface
- `N_LINES`, default 8: number of spike lines decoded in parallel.
- `LOG_T`, default `` `log_time_period ``: the window is 2^LOG_T cycles.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `start` input 1: request a new window; accepted in IDLE, or in HOLD when `out_ready` is also high.
- `spike_in` input N_LINES: level-coded spikes; once high, a line stays high until the window ends.
- `time_val` output LOG_T+1: current window time, 0..2^LOG_T-1 during CAPTURE, 0 otherwise.
- `busy` output 1: high in CAPTURE.
- `spike_time` output N_LINES×LOG_T: decoded time per line.
- `no_spike` output N_LINES: 1 means the line never fired. Polarity matches generator `should_spike`, where 0 means a spike.
- `out_valid` output 1: results are stable and valid.
- `out_ready` input 1: consumer accepts the results.
- `err` output N_LINES: monotonicity violation per line (see Configuration).

## Operation
- The FSM has three states: IDLE, CAPTURE, HOLD.
- IDLE → CAPTURE on `start`. On entry, clear all lane state, set `no_spike` to all-ones, and set `time_val` to 0.
- In CAPTURE, each cycle with `time_val` = c:
  - For each lane not yet captured, if `spike_in[i]`=1, latch `spike_time[i]`=c and clear `no_spike[i]`.
  - Then increment `time_val`.
- CAPTURE → HOLD after the cycle with c = 2^LOG_T-1. `time_val` returns to 0.
- Lanes that never fired report `spike_time` = all-ones (2^LOG_T-1) and `no_spike`=1.
- In HOLD, `out_valid`=1 and the outputs are frozen. On `out_ready`:
  - → CAPTURE if `start` is also high (back-to-back window).
  - → IDLE otherwise.
- `start` is ignored in CAPTURE and in HOLD without `out_ready`.
- Round-trip property: a generator fed `time_val` and spike time s decodes to exactly s for every s in 0..2^LOG_T-1.

## Timing
- Reset values:
  - state IDLE
  - `time_val`=0, `busy`=0, `out_valid`=0
  - `spike_time`=0, `no_spike`=all-ones, `err`=0
- `start` is sampled at edge k. The first CAPTURE cycle (`time_val`=0) is cycle k+1. `out_valid` rises at cycle k+1+2^LOG_T.
- Capture is registered: `spike_in` sampled at the edge ending the cycle with `time_val`=c yields time c. A line high in the first CAPTURE cycle decodes to 0.
- A lane that is already captured ignores further input.
- All lanes rising in the same cycle each record the same c.
- `rst` mid-window or mid-HOLD aborts immediately to reset values. No partial result is presented.
- Back-to-back windows: with `out_ready` and `start` both high in HOLD, the next cycle is CAPTURE with `time_val`=0. There is no idle bubble.

## Configuration
- Macro: `SPIKE_CAPTURE_MONOTONIC_CHECK_EN`.
- Defined: in CAPTURE, a captured lane seen low sets its sticky `err[i]`. `err` is cleared on window start and on reset, and is valid alongside `out_valid`.
- Undefined: `err` is tied to 0 and the check logic is removed. Decode behaviour is identical either way.

## Structure
- Shared package `spike_pkg`:
  - `capture_state_t` enum (IDLE, CAPTURE, HOLD)
  - `T_MAX` = 2^LOG_T-1
  - the no-spike sentinel constant
- Sub-module `spike_capture_lane`, one instance per line. It holds the captured flag, `spike_time`, `no_spike`, and `err`. Inputs: clear, capture-enable, current time, `spike_in` bit.
- The top level holds the FSM, the time counter and the handshake.

## Test plan
Parameters for all scenarios: LOG_T=3, N_LINES=4.
1. Lines rise at t=0, 3, 7 and never → `spike_time`={0,3,7,7}, `no_spike`=4'b1000, `out_valid` at start+9.
2. Loopback through four generators with spike times {5,1,6,2} driven by `time_val` → decoded {5,1,6,2}, `no_spike`=0.
3. Hold `out_ready`=0 for 5 cycles, then assert it with `start`=1 → outputs frozen during HOLD, next cycle `busy`=1 with `time_val`=0, no IDLE cycle.
4. Assert `rst` at `time_val`=4 → next cycle `time_val`=0, `busy`=0, `no_spike`=4'hF, no `out_valid`.
5. `start` pulsed at `time_val`=2 of an active window → ignored, window completes on schedule.
6. With the macro defined, line 0 rises at t=2 and falls at t=4 → `spike_time[0]`=2, `err`=4'b0001. With the macro undefined → `err`=0.

Source files
------------

// File: rtl/spike_pkg.sv
// spike_pkg: shared state enum, window constants and no-spike sentinel for spike_time_capture (SPIKE_CAPTURE_MONOTONIC_CHECK_EN).
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif
package spike_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} capture_state_t;
  function automatic int t_max(input int log_t);
    return (1 << log_t) - 1;
  endfunction
  localparam int LOG_T_DEFAULT = `LOG_TIME_PERIOD;
  localparam int T_MAX = t_max(LOG_T_DEFAULT);
  localparam int NO_SPIKE_TIME = T_MAX;
endpackage

// File: rtl/spike_capture_lane.sv
// spike_capture_lane: per-line first-rise latch with sticky monotonicity error (SPIKE_CAPTURE_MONOTONIC_CHECK_EN).
module spike_capture_lane
  import spike_pkg::*;
#(
  parameter int LOG_T = LOG_T_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [LOG_T-1:0] t,
  input  logic             s,
  output logic [LOG_T-1:0] spike_time,
  output logic             no_spike,
  output logic             err
);
  logic [LOG_T-1:0] time_q, time_d;
  logic             ns_q, ns_d, hit;
  // no_spike doubles as the not-yet-captured flag
  always_comb begin
    hit    = en && ns_q && s;
    time_d = clr ? LOG_T'(t_max(LOG_T)) : hit ? t : time_q;
    ns_d   = clr ? 1'b1 : hit ? 1'b0 : ns_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      time_q <= '0;
      ns_q   <= 1'b1;
    end else begin
      time_q <= time_d;
      ns_q   <= ns_d;
    end
  end
  assign spike_time = time_q;
  assign no_spike   = ns_q;
`ifdef SPIKE_CAPTURE_MONOTONIC_CHECK_EN
  logic err_q, err_d;
  always_comb err_d = clr ? 1'b0 : (en && !ns_q && !s) ? 1'b1 : err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: rtl/spike_time_capture.sv
// spike_time_capture: window FSM, shared time counter and valid/ready handshake over N capture lanes.
// Define SPIKE_CAPTURE_MONOTONIC_CHECK_EN to enable per-line err reporting.
module spike_time_capture
  import spike_pkg::*;
#(
  parameter int N_LINES = 8,
  parameter int LOG_T   = LOG_T_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_LINES-1:0]       spike_in,
  output logic [LOG_T:0]           time_val,
  output logic                     busy,
  output logic [N_LINES*LOG_T-1:0] spike_time,
  output logic [N_LINES-1:0]       no_spike,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_LINES-1:0]       err
);
  localparam logic [LOG_T:0] TM = (LOG_T+1)'(t_max(LOG_T));
  capture_state_t state_q, state_d;
  logic [LOG_T:0] time_q, time_d;
  logic busy_q, busy_d, valid_q, valid_d, go, last;
  always_comb begin
    go      = start && (state_q == IDLE || (state_q == HOLD && out_ready));
    last    = time_q == TM;
    state_d = go ? CAPTURE :
              state_q == CAPTURE ? (last ? HOLD : CAPTURE) :
              (state_q == HOLD && out_ready) ? IDLE : state_q;
    time_d  = (state_q == CAPTURE && !last) ? time_q + 1'b1 : '0;
    busy_d  = state_d == CAPTURE;
    valid_d = state_d == HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      time_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign time_val  = time_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  for (genvar i = 0; i < N_LINES; i++) begin : g_lane
    spike_capture_lane #(.LOG_T(LOG_T)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr       (go),
      .en        (state_q == CAPTURE),
      .t         (time_q[LOG_T-1:0]),
      .s         (spike_in[i]),
      .spike_time(spike_time[i*LOG_T +: LOG_T]),
      .no_spike  (no_spike[i]),
      .err       (err[i])
    );
  end
endmodule

// File: tb/tb_spike_time_capture.sv
// tb_spike_time_capture: directed checks of window decode, handshake, abort and the optional err feature (SPIKE_CAPTURE_MONOTONIC_CHECK_EN).
module tb_spike_time_capture;
  logic        clk = 0, rst = 1, start = 0, out_ready = 0, loop_en = 0;
  logic [3:0]  spike_in, spike_drv = 0, gen;
  logic [3:0]  time_val;
  logic        busy, out_valid;
  logic [11:0] spike_time;
  logic [3:0]  no_spike, err;
  logic [3:0][2:0] gen_s = {3'd2, 3'd6, 3'd1, 3'd5};
  int n_cmp = 0, n_err = 0;
`ifdef SPIKE_CAPTURE_MONOTONIC_CHECK_EN
  localparam logic [3:0] ERR_EXP = 4'b0001;
`else
  localparam logic [3:0] ERR_EXP = 4'b0000;
`endif

  spike_time_capture #(.N_LINES(4), .LOG_T(3)) dut (
    .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .time_val(time_val),
    .busy(busy), .spike_time(spike_time), .no_spike(no_spike), .out_valid(out_valid),
    .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  // level-coded generators: line i high once time_val reaches its spike time
  always_comb begin
    gen = '0;
    for (int i = 0; i < 4; i++) gen[i] = busy && (time_val >= {1'b0, gen_s[i]});
  end
  assign spike_in = loop_en ? gen : spike_drv;

  task automatic set_lines(input int j, input logic [3:0][3:0] r, input logic [3:0][3:0] f);
    for (int i = 0; i < 4; i++) spike_drv[i] = (j >= int'(r[i])) && (j < int'(f[i]));
  endtask

  task automatic drain;
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1; repeat (2) @(negedge clk);
    n_cmp++;
    if (time_val !== 0 || busy !== 0 || out_valid !== 0 || spike_time !== 0 || no_spike !== 4'hF || err !== 0) begin
      n_err++; $display("FAIL reset: t=%0d busy=%b v=%b st=%o ns=%b err=%b, want 0 0 0 0 1111 0000", time_val, busy, out_valid, spike_time, no_spike, err);
    end
    rst = 0; @(negedge clk);
    n_cmp++;
    if (busy !== 0 || out_valid !== 0) begin
      n_err++; $display("FAIL idle: busy=%b v=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic;
    logic [3:0][3:0] r, f;
    r = {4'd8, 4'd7, 4'd3, 4'd0}; f = {4{4'd8}};
    start = 1; @(negedge clk); start = 0;
    for (int j = 0; j < 8; j++) begin
      set_lines(j, r, f);
      n_cmp++;
      if (time_val !== 4'(j) || busy !== 1 || out_valid !== 0) begin
        n_err++; $display("FAIL basic_cap j=%0d: t=%0d busy=%b v=%b, want t=%0d 1 0", j, time_val, busy, out_valid, j);
      end
      @(negedge clk);
    end
    spike_drv = 0;
    n_cmp++;
    if (out_valid !== 1 || busy !== 0 || time_val !== 0 || spike_time !== 12'o7730 || no_spike !== 4'b1000) begin
      n_err++; $display("FAIL basic_res: v=%b busy=%b t=%0d st=%o ns=%b, want 1 0 0 7730 1000", out_valid, busy, time_val, spike_time, no_spike);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 5; k++) begin
      spike_drv = 4'hF; start = (k == 2);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1 || busy !== 0 || spike_time !== 12'o7730 || no_spike !== 4'b1000) begin
        n_err++; $display("FAIL hold k=%0d: v=%b busy=%b st=%o ns=%b, want 1 0 7730 1000", k, out_valid, busy, spike_time, no_spike);
      end
    end
    spike_drv = 0; start = 1; out_ready = 1;
    @(negedge clk);
    start = 0; out_ready = 0;
    n_cmp++;
    if (busy !== 1 || time_val !== 0 || out_valid !== 0) begin
      n_err++; $display("FAIL b2b_enter: busy=%b t=%0d v=%b, want 1 0 0", busy, time_val, out_valid);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1 || spike_time !== 12'o7777 || no_spike !== 4'hF) begin
      n_err++; $display("FAIL b2b_res: v=%b st=%o ns=%b, want 1 7777 1111", out_valid, spike_time, no_spike);
    end
    drain;
    n_cmp++;
    if (out_valid !== 0 || busy !== 0) begin
      n_err++; $display("FAIL drain_idle: v=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_loopback;
    loop_en = 1; start = 1; @(negedge clk); start = 0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1 || spike_time !== 12'o2615 || no_spike !== 0) begin
      n_err++; $display("FAIL loopback: v=%b st=%o ns=%b, want 1 2615 0000", out_valid, spike_time, no_spike);
    end
    drain; loop_en = 0;
  endtask

  task automatic test_abort;
    start = 1; @(negedge clk); start = 0; spike_drv = 4'b0011;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (time_val !== 4) begin
      n_err++; $display("FAIL abort_pre: t=%0d want 4", time_val);
    end
    rst = 1; @(negedge clk);
    n_cmp++;
    if (time_val !== 0 || busy !== 0 || no_spike !== 4'hF || out_valid !== 0 || spike_time !== 0 || err !== 0) begin
      n_err++; $display("FAIL abort: t=%0d busy=%b ns=%b v=%b st=%o err=%b, want 0 0 1111 0 0 0000", time_val, busy, no_spike, out_valid, spike_time, err);
    end
    rst = 0; spike_drv = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 0 || busy !== 0) begin
        n_err++; $display("FAIL abort_idle k=%0d: v=%b busy=%b want 0 0", k, out_valid, busy);
      end
    end
  endtask

  task automatic test_start_ignored;
    logic [3:0][3:0] r, f;
    r = {4{4'd1}}; f = {4{4'd8}};
    start = 1; @(negedge clk); start = 0;
    for (int j = 0; j < 8; j++) begin
      set_lines(j, r, f); start = (j == 2);
      n_cmp++;
      if (time_val !== 4'(j) || busy !== 1 || out_valid !== 0) begin
        n_err++; $display("FAIL ign_cap j=%0d: t=%0d busy=%b v=%b, want t=%0d 1 0", j, time_val, busy, out_valid, j);
      end
      @(negedge clk);
    end
    start = 0; spike_drv = 0;
    n_cmp++;
    if (out_valid !== 1 || spike_time !== 12'o1111 || no_spike !== 0) begin
      n_err++; $display("FAIL ign_res: v=%b st=%o ns=%b, want 1 1111 0000", out_valid, spike_time, no_spike);
    end
    drain;
  endtask

  task automatic test_same_cycle;
    logic [3:0][3:0] r, f;
    r = {4{4'd5}}; f = {4{4'd8}};
    start = 1; @(negedge clk); start = 0;
    for (int j = 0; j < 8; j++) begin
      set_lines(j, r, f); @(negedge clk);
    end
    spike_drv = 0;
    n_cmp++;
    if (out_valid !== 1 || spike_time !== 12'o5555 || no_spike !== 0 || err !== 0) begin
      n_err++; $display("FAIL same_cycle: v=%b st=%o ns=%b err=%b, want 1 5555 0000 0000", out_valid, spike_time, no_spike, err);
    end
    drain;
  endtask

  task automatic test_err;
    logic [3:0][3:0] r, f;
    r = {4'd8, 4'd8, 4'd8, 4'd2}; f = {4'd8, 4'd8, 4'd8, 4'd4};
    start = 1; @(negedge clk); start = 0;
    for (int j = 0; j < 8; j++) begin
      set_lines(j, r, f); @(negedge clk);
    end
    spike_drv = 0;
    n_cmp++;
    if (out_valid !== 1 || spike_time !== 12'o7772 || no_spike !== 4'b1110 || err !== ERR_EXP) begin
      n_err++; $display("FAIL err: v=%b st=%o ns=%b err=%b, want 1 7772 1110 %b", out_valid, spike_time, no_spike, err, ERR_EXP);
    end
    start = 1; out_ready = 1; @(negedge clk); start = 0; out_ready = 0;
    n_cmp++;
    if (err !== 0 || no_spike !== 4'hF || busy !== 1) begin
      n_err++; $display("FAIL err_clear: err=%b ns=%b busy=%b, want 0000 1111 1", err, no_spike, busy);
    end
    repeat (8) @(negedge clk);
    drain;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_back_to_back;
    test_loopback;
    test_abort;
    test_start_ignored;
    test_same_cycle;
    test_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
